pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the MIPS cores: holds the PC, computes the next fetch address from sequential, branch, jump and register-jump requests, and arbitrates interrupt and exception entry against kernel mode. It sits between the control decoder and instruction ROM and replaces the inline PC register/next-PC mux. It adds a stall handshake, a sticky interrupt-pending latch, parametrised vectors and an optional EPC/eret return path.

## Interface
- AW, 32: address width, legal range 29..64.
- KBIT, AW-1: kernel-mode bit position in PC.
- RESET_VEC, 0: PC after reset.
- IRQ_VEC, 32'h80000004 zero-extended to AW: interrupt entry address.
- EXC_VEC, 32'h80000008 zero-extended to AW: exception entry address.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  1 = hold PC and all state this cycle.
- pc_src  in  3  0 seq, 1 branch, 2 jump, 3 jr, 4 eret, 5..7 treated as seq.
- branch_taken  in  1  qualifies pc_src=1.
- imm16  in  16  branch offset in words, signed.
- instr_index  in  26  jump field.
- reg_target  in  AW  jr target.
- irq  in  1  interrupt request, level.
- exc  in  1  current instruction is illegal, level, valid with pc.
- pc  out  AW  current fetch address.
- pc_plus_4  out  AW  pc+4 mod 2^AW.
- kernel  out  1  equals pc[KBIT].
- trap_take  out  1  combinational; IRQ or exception entry at next edge.
- trap_is_irq  out  1  valid with trap_take.
- link  out  AW  return address for trap_take (equals pc).
- epc  out  AW  saved return address (0 when EPC disabled).

## Operation
- Next-PC priority, highest first: exc; pending IRQ (user mode only); pc_src request.
- exc: next = EXC_VEC, trap_take=1, trap_is_irq=0. Accepted in user and kernel mode.
- IRQ: irq_pend set at any edge where irq=1. Taken when irq_pend=1, kernel=0, exc=0: next = IRQ_VEC, trap_take=1, trap_is_irq=1, irq_pend cleared at that edge. irq_pend is sticky; deasserting irq does not clear it.
- In kernel mode the IRQ stays pending and is taken on the first unstalled user-mode cycle.
- Trap entry abandons the instruction at pc; link=pc, and with EPC the register epc<=pc.
- seq: next = pc_plus_4.
- branch: taken -> pc_plus_4 + (sext(imm16)<<2) mod 2^AW; not taken -> pc_plus_4.
- jump: next = {pc_plus_4[AW-1:28], instr_index, 2'b00}.
- jr: next = reg_target.
- User mode (kernel=0): for jump/jr/branch targets bit KBIT is forced to 0. User code cannot enter kernel space except by trap.
- Kernel mode: targets unmodified. A jr or eret to an address with KBIT=0 returns to user mode.
- eret: see Configuration.
- stall=1: pc, epc and irq_pend hold. irq_pend may still set. trap_take is forced 0.
- Same edge irq rises and exc=1: exception taken; irq_pend set and remains pending.

## Timing
- All registers update on rising clk. reset asynchronously forces pc=RESET_VEC, epc=0, irq_pend=0.
- Reset outputs: pc_plus_4=RESET_VEC+4, kernel=RESET_VEC[KBIT], trap_take=0, link=RESET_VEC.
- Redirect latency 1 cycle: request in cycle n gives new pc in cycle n+1. No bubbles are inserted.
- IRQ latency: irq high at edge e sets irq_pend. Earliest entry is at edge e+1, with pc=IRQ_VEC in the following cycle.
- Reset assertion mid-trap discards the trap; no partial epc update.
- Wrap-around: pc=2^AW-4 with seq gives pc=0.

## Configuration
- PCSEQ_EPC_EN defined:
  - epc register is implemented and written on trap entry.
  - pc_src=4 (eret) sets next=epc when kernel=1.
  - eret in user mode is treated as seq.
- PCSEQ_EPC_EN undefined:
  - no epc register; epc output is 0.
  - pc_src=4 is treated as seq.
  - Return is through jr on the link value the regfile stored in $26.

## Test plan
- Reset test: reset while pc=0x40, then release -> pc=0, epc=0. Seq step gives 0x4, 0x8.
- Branch test: pc=0x100, pc_src=1, taken, imm16=0xFFFE -> pc=0xFC. Repeat not taken -> 0x104.
- Kernel-bit masking test, jump then jr:
  - User mode, jr with reg_target=0x80000010 -> pc=0x00000010.
  - Kernel mode, same request -> pc=0x80000010.
- IRQ pending test:
  - 1-cycle irq pulse while kernel=1 -> no trap.
  - Then jr 0x200 (kernel exit) -> trap_take next cycle, pc=0x80000004, link=0x200, irq_pend=0.
- Priority and stall test:
  - exc=1 with irq pending and stall=1 for 3 cycles -> pc holds, trap_take=0.
  - Stall release -> pc=0x80000008, irq still pending.
- EPC round trip (PCSEQ_EPC_EN):
  - IRQ at pc=0x300 -> epc=0x300.
  - eret from kernel -> pc=0x300, kernel=0.
  - Without the macro, eret -> pc+4.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, user/kernel masking, and trap entry.
// Optional EPC/eret return path enabled by defining PCSEQ_EPC_EN.
module pc_sequencer #(
  parameter int unsigned     AW        = 32,
  parameter int unsigned     KBIT      = AW - 1,
  parameter logic [AW-1:0]   RESET_VEC = '0,
  parameter logic [AW-1:0]   IRQ_VEC   = AW'(32'h8000_0004),
  parameter logic [AW-1:0]   EXC_VEC   = AW'(32'h8000_0008)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [2:0]    pc_src,
  input  logic          branch_taken,
  input  logic [15:0]   imm16,
  input  logic [25:0]   instr_index,
  input  logic [AW-1:0] reg_target,
  input  logic          irq,
  input  logic          exc,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus_4,
  output logic          kernel,
  output logic          trap_take,
  output logic          trap_is_irq,
  output logic [AW-1:0] link,
  output logic [AW-1:0] epc
);

  localparam int unsigned BR_EXT = AW - 18;

  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_JR     = 3'd3,
    SRC_ERET   = 3'd4
  } pc_src_e;

  logic          irq_pend;
  logic          irq_take;
  logic          redirect;
  logic [AW-1:0] kmask;
  logic [AW-1:0] br_off;
  logic [AW-1:0] br_tgt;
  logic [AW-1:0] j_tgt;
  logic [AW-1:0] req_tgt;
  logic [AW-1:0] src_tgt;
  logic [AW-1:0] pc_next;

`ifdef PCSEQ_EPC_EN
  logic [AW-1:0] epc_q;
`endif

  assign pc_plus_4 = pc + AW'(4);
  assign kernel    = pc[KBIT];
  assign link      = pc;
  assign kmask     = ~(AW'(1) << KBIT);

  assign br_off = {{BR_EXT{imm16[15]}}, imm16, 2'b00};
  assign br_tgt = pc_plus_4 + br_off;
  assign j_tgt  = {pc_plus_4[AW-1:28], instr_index, 2'b00};

  // Exception outranks a pending IRQ; IRQs wait out kernel mode and stalls.
  assign irq_take    = ~stall & ~exc & irq_pend & ~kernel;
  assign trap_take   = ~stall & (exc | (irq_pend & ~kernel));
  assign trap_is_irq = irq_take;

  // Requested target from the decoder, before trap override.
  always_comb begin
    src_tgt  = pc_plus_4;
    redirect = 1'b0;
    case (pc_src_e'(pc_src))
      SRC_BRANCH: begin
        if (branch_taken) begin
          src_tgt  = br_tgt;
          redirect = 1'b1;
        end
      end
      SRC_JUMP: begin
        src_tgt  = j_tgt;
        redirect = 1'b1;
      end
      SRC_JR: begin
        src_tgt  = reg_target;
        redirect = 1'b1;
      end
`ifdef PCSEQ_EPC_EN
      SRC_ERET: begin
        if (kernel) src_tgt = epc_q;
      end
`endif
      default: ;
    endcase
  end

  // User code may only reach kernel space through a trap.
  assign req_tgt = (redirect && !kernel) ? (src_tgt & kmask) : src_tgt;

  always_comb begin
    pc_next = req_tgt;
    if (exc)           pc_next = EXC_VEC;
    else if (irq_take) pc_next = IRQ_VEC;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_VEC;
      irq_pend <= 1'b0;
    end else begin
      irq_pend <= (irq_pend & ~irq_take) | irq;
      if (!stall) pc <= pc_next;
    end
  end

`ifdef PCSEQ_EPC_EN
  // Return address of the abandoned instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          epc_q <= '0;
    else if (trap_take) epc_q <= pc;
  end

  assign epc = epc_q;
`else
  assign epc = '0;
`endif

endmodule
